// File: rtl/l2_reqs_sched_pkg.sv
// Shared constants and types for the L2 request-buffer scheduler.
package l2_reqs_sched_pkg;

  // Default geometry of the request buffer and starvation threshold
  localparam int L2_N_REQS       = 4;
  localparam int L2_REQS_BITS    = 2;
  localparam int L2_STARVE_LIMIT = 8;

  // Request-buffer opcodes
  localparam logic [2:0] L2_REQS_IDLE       = 3'd0;
  localparam logic [2:0] L2_REQS_LOOKUP     = 3'd1;
  localparam logic [2:0] L2_REQS_PEEK_REQ   = 3'd2;
  localparam logic [2:0] L2_REQS_PEEK_FLUSH = 3'd3;
  localparam logic [2:0] L2_REQS_PEEK_FWD   = 3'd4;

  // Requester encodings; bit 1 set means an allocating requester
  localparam logic [1:0] L2_SCHED_SRC_RSP   = 2'd0;
  localparam logic [1:0] L2_SCHED_SRC_FWD   = 2'd1;
  localparam logic [1:0] L2_SCHED_SRC_CPU   = 2'd2;
  localparam logic [1:0] L2_SCHED_SRC_FLUSH = 2'd3;

  typedef enum logic [1:0] {
    L2_SCHED_IDLE,
    L2_SCHED_PEEK,
    L2_SCHED_RESULT
  } l2_sched_state_t;

  // Opcode driven on the buffer port for a given requester
  function automatic logic [2:0] src_opcode(input logic [1:0] src);
    logic [2:0] op;
    case (src)
      L2_SCHED_SRC_RSP: op = L2_REQS_LOOKUP;
      L2_SCHED_SRC_FWD: op = L2_REQS_PEEK_FWD;
      L2_SCHED_SRC_CPU: op = L2_REQS_PEEK_REQ;
      default:          op = L2_REQS_PEEK_FLUSH;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/l2_reqs_sched_arb.sv
// Combinational winner select: rsp > fwd > {cpu, flush} round-robin,
// with a starved allocating requester promoted above rsp/fwd.
module l2_reqs_sched_arb
  import l2_reqs_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = L2_STARVE_LIMIT,
  parameter int STARVE_W     = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                rsp_valid,
  input  logic                fwd_valid,
  input  logic                cpu_valid,
  input  logic                flush_valid,
  input  logic                reqs_full,
  input  logic                rr_flush,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                gnt_valid,
  output logic [1:0]          gnt_src,
  output logic                alloc_lost
);

  logic       alloc_elig;
  logic       alloc_forced;
  logic [1:0] alloc_src;

  // Priority select; alloc_lost flags an eligible allocator beaten by rsp/fwd
  always_comb begin
    alloc_elig   = !reqs_full && (cpu_valid || flush_valid);
    alloc_src    = (flush_valid && (!cpu_valid || rr_flush)) ? L2_SCHED_SRC_FLUSH
                                                             : L2_SCHED_SRC_CPU;
    alloc_forced = alloc_elig && (starve_cnt == STARVE_W'(STARVE_LIMIT));
    gnt_valid    = 1'b1;
    gnt_src      = L2_SCHED_SRC_RSP;
    alloc_lost   = 1'b0;
    if (alloc_forced) begin
      gnt_src = alloc_src;
    end else if (rsp_valid) begin
      gnt_src    = L2_SCHED_SRC_RSP;
      alloc_lost = alloc_elig;
    end else if (fwd_valid) begin
      gnt_src    = L2_SCHED_SRC_FWD;
      alloc_lost = alloc_elig;
    end else if (alloc_elig) begin
      gnt_src = alloc_src;
    end else begin
      gnt_valid = 1'b0;
    end
  end

endmodule

// File: rtl/l2_reqs_sched.sv
// L2 request-buffer scheduler: serialises rsp/fwd/cpu/flush onto the
// buffer opcode port, latches peek results and tracks occupancy.
module l2_reqs_sched
  import l2_reqs_sched_pkg::*;
#(
  parameter int N_REQS       = L2_N_REQS,
  parameter int REQS_BITS    = L2_REQS_BITS,
  parameter int STARVE_LIMIT = L2_STARVE_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rsp_valid,
  output logic                 rsp_ready,
  input  logic                 fwd_valid,
  output logic                 fwd_ready,
  input  logic                 cpu_valid,
  output logic                 cpu_ready,
  input  logic                 flush_valid,
  output logic                 flush_ready,
  input  logic                 free_valid,
  input  logic                 set_set_conflict_reqs,
  input  logic                 reqs_hit,
  input  logic [REQS_BITS-1:0] reqs_i,
  output logic [2:0]           reqs_op_code,
  output logic                 fill_reqs,
  output logic                 fill_reqs_flush,
  output logic                 done_valid,
  output logic [1:0]           done_src,
  output logic                 done_hit,
  output logic                 done_conflict,
  output logic [REQS_BITS-1:0] done_idx,
  output logic [REQS_BITS:0]   reqs_cnt,
  output logic                 reqs_full,
  output logic                 ovf_err
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int CNT_W    = REQS_BITS + 1;

  // Saturating occupancy update; returns {overflow, next count}
  function automatic logic [CNT_W:0] occ_next(input logic [CNT_W-1:0] cnt,
                                              input logic inc, input logic dec);
    logic [CNT_W:0] r;
    r = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == CNT_W'(N_REQS)) r[CNT_W] = 1'b1;
      else                       r[CNT_W-1:0] = cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) r[CNT_W] = 1'b1;
      else           r[CNT_W-1:0] = cnt - CNT_W'(1);
    end
    return r;
  endfunction

  l2_sched_state_t     state_q, state_d;
  logic [1:0]          src_p1;
  logic                conflict_p2;
  logic                rr_flush;
  logic [STARVE_W-1:0] starve_cnt;
  logic                gnt_valid;
  logic [1:0]          gnt_src;
  logic                alloc_lost;
  logic                grant;
  logic [CNT_W:0]      occ_upd;

  l2_reqs_sched_arb #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .STARVE_W     (STARVE_W)
  ) u_arb (
    .rsp_valid   (rsp_valid),
    .fwd_valid   (fwd_valid),
    .cpu_valid   (cpu_valid),
    .flush_valid (flush_valid),
    .reqs_full   (reqs_full),
    .rr_flush    (rr_flush),
    .starve_cnt  (starve_cnt),
    .gnt_valid   (gnt_valid),
    .gnt_src     (gnt_src),
    .alloc_lost  (alloc_lost)
  );

  // rst is active-low: no grant is issued while the block is held in reset
  assign grant     = (state_q == L2_SCHED_IDLE) && gnt_valid && rst;
  assign reqs_full = (reqs_cnt == CNT_W'(N_REQS));
  assign occ_upd   = occ_next(reqs_cnt, fill_reqs || fill_reqs_flush, free_valid);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= L2_SCHED_IDLE;
    else      state_q <= state_d;
  end

  // Next state and all sequence outputs
  always_comb begin
    state_d         = state_q;
    rsp_ready       = 1'b0;
    fwd_ready       = 1'b0;
    cpu_ready       = 1'b0;
    flush_ready     = 1'b0;
    reqs_op_code    = L2_REQS_IDLE;
    fill_reqs       = 1'b0;
    fill_reqs_flush = 1'b0;
    done_valid      = 1'b0;
    done_src        = L2_SCHED_SRC_RSP;
    done_hit        = 1'b0;
    done_conflict   = 1'b0;
    done_idx        = '0;
    case (state_q)
      // ---- grant: winner gets ready pulse and its opcode this cycle
      L2_SCHED_IDLE: begin
        if (grant) begin
          rsp_ready    = (gnt_src == L2_SCHED_SRC_RSP);
          fwd_ready    = (gnt_src == L2_SCHED_SRC_FWD);
          cpu_ready    = (gnt_src == L2_SCHED_SRC_CPU);
          flush_ready  = (gnt_src == L2_SCHED_SRC_FLUSH);
          reqs_op_code = src_opcode(gnt_src);
          state_d      = L2_SCHED_PEEK;
        end
      end
      // ---- p1: opcode held while the buffer registers its result
      L2_SCHED_PEEK: begin
        reqs_op_code = src_opcode(src_p1);
        state_d      = L2_SCHED_RESULT;
      end
      // ---- p2: report result, fill only when allocation is clean
      L2_SCHED_RESULT: begin
        done_valid = 1'b1;
        done_src   = src_p1;
        done_idx   = reqs_i;
        case (src_p1)
          L2_SCHED_SRC_CPU: begin
            if (conflict_p2) begin
              done_conflict = 1'b1;
            end else begin
              fill_reqs = 1'b1;
              done_hit  = 1'b1;
            end
          end
          L2_SCHED_SRC_FLUSH: begin
            fill_reqs_flush = 1'b1;
            done_hit        = 1'b1;
          end
          default: done_hit = reqs_hit;
        endcase
        state_d = L2_SCHED_IDLE;
      end
      default: state_d = L2_SCHED_IDLE;
    endcase
  end

  // Latch winner at grant and cpu set-conflict at the end of the peek cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_p1      <= L2_SCHED_SRC_RSP;
      conflict_p2 <= 1'b0;
    end else begin
      if (grant) src_p1 <= gnt_src;
      if (state_q == L2_SCHED_PEEK)
        conflict_p2 <= (src_p1 == L2_SCHED_SRC_CPU) && set_set_conflict_reqs;
    end
  end

  // Round-robin pointer and starvation counter for the allocating requesters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_flush   <= 1'b0;
      starve_cnt <= '0;
    end else if (grant && gnt_src[1]) begin
      rr_flush   <= ~rr_flush;
      starve_cnt <= '0;
    end else if (grant && alloc_lost && (starve_cnt < STARVE_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Occupancy counter with sticky under/overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reqs_cnt <= '0;
      ovf_err  <= 1'b0;
    end else begin
      reqs_cnt <= occ_upd[CNT_W-1:0];
      ovf_err  <= ovf_err | occ_upd[CNT_W];
    end
  end

endmodule

// File: tb/tb_l2_reqs_sched.sv
// Directed bench for the L2 request-buffer scheduler.
module tb_l2_reqs_sched;
  import l2_reqs_sched_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rsp_valid, fwd_valid, cpu_valid, flush_valid;
  logic       rsp_ready, fwd_ready, cpu_ready, flush_ready;
  logic       free_valid, set_set_conflict_reqs, reqs_hit;
  logic [1:0] reqs_i;
  logic [2:0] reqs_op_code;
  logic       fill_reqs, fill_reqs_flush;
  logic       done_valid, done_hit, done_conflict;
  logic [1:0] done_src, done_idx;
  logic [2:0] reqs_cnt;
  logic       reqs_full, ovf_err;

  int n_chk = 0;
  int n_err = 0;

  l2_reqs_sched dut (
    .clk                   (clk),
    .rst                   (rst),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .fwd_valid             (fwd_valid),
    .fwd_ready             (fwd_ready),
    .cpu_valid             (cpu_valid),
    .cpu_ready             (cpu_ready),
    .flush_valid           (flush_valid),
    .flush_ready           (flush_ready),
    .free_valid            (free_valid),
    .set_set_conflict_reqs (set_set_conflict_reqs),
    .reqs_hit              (reqs_hit),
    .reqs_i                (reqs_i),
    .reqs_op_code          (reqs_op_code),
    .fill_reqs             (fill_reqs),
    .fill_reqs_flush       (fill_reqs_flush),
    .done_valid            (done_valid),
    .done_src              (done_src),
    .done_hit              (done_hit),
    .done_conflict         (done_conflict),
    .done_idx              (done_idx),
    .reqs_cnt              (reqs_cnt),
    .reqs_full             (reqs_full),
    .ovf_err               (ovf_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rsp_valid = 0; fwd_valid = 0; cpu_valid = 0; flush_valid = 0;
    free_valid = 0; set_set_conflict_reqs = 0; reqs_hit = 0; reqs_i = 0;
    rst = 0;
    tick();
    rst = 1;
    settle();
  endtask

  // One full cpu/flush allocation sequence starting in an IDLE cycle
  task automatic alloc_seq(input bit use_flush, input bit conf, input logic [1:0] idx,
                           input bit free_at_res, input logic [2:0] cnt_after);
    if (use_flush) flush_valid = 1; else cpu_valid = 1;
    settle();
    chk("alloc_ready", use_flush ? flush_ready : cpu_ready, 1);
    chk("alloc_op", reqs_op_code, use_flush ? 32'd3 : 32'd2);
    tick();
    cpu_valid = 0; flush_valid = 0;
    set_set_conflict_reqs = conf; reqs_i = idx;
    settle();
    chk("alloc_peek_op", reqs_op_code, use_flush ? 32'd3 : 32'd2);
    tick();
    set_set_conflict_reqs = 0; free_valid = free_at_res;
    settle();
    chk("alloc_done_valid", done_valid, 1);
    chk("alloc_done_src", done_src, use_flush ? 32'd3 : 32'd2);
    chk("alloc_done_hit", done_hit, !conf);
    chk("alloc_done_conflict", done_conflict, conf);
    chk("alloc_done_idx", done_idx, idx);
    chk("alloc_fill", fill_reqs, !use_flush && !conf);
    chk("alloc_fill_flush", fill_reqs_flush, use_flush);
    tick();
    free_valid = 0;
    settle();
    chk("alloc_cnt", reqs_cnt, cnt_after);
  endtask

  initial begin
    rst = 0;
    rsp_valid = 1; fwd_valid = 0; cpu_valid = 0; flush_valid = 0;
    free_valid = 0; set_set_conflict_reqs = 0; reqs_hit = 0; reqs_i = 0;
    tick();
    tick();
    settle();
    chk("rst_op", reqs_op_code, 0);
    chk("rst_rsp_ready", rsp_ready, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_fill", fill_reqs, 0);
    chk("rst_cnt", reqs_cnt, 0);
    chk("rst_full", reqs_full, 0);
    chk("rst_ovf", ovf_err, 0);

    // rsp lookup: grant, held opcode, result two cycles after grant
    tick();
    rst = 1;
    settle();
    chk("rsp_ready", rsp_ready, 1);
    chk("rsp_op_c0", reqs_op_code, 1);
    tick();
    rsp_valid = 0; reqs_hit = 1; reqs_i = 2;
    settle();
    chk("rsp_op_c1", reqs_op_code, 1);
    chk("rsp_ready_c1", rsp_ready, 0);
    tick();
    settle();
    chk("rsp_done_valid", done_valid, 1);
    chk("rsp_done_src", done_src, 0);
    chk("rsp_done_hit", done_hit, 1);
    chk("rsp_done_idx", done_idx, 2);
    chk("rsp_no_fill", fill_reqs, 0);
    tick();
    reqs_hit = 0;
    settle();
    chk("rsp_back_idle", done_valid, 0);
    chk("rsp_op_idle", reqs_op_code, 0);

    // cpu with conflict, then clean allocations up to full
    alloc_seq(0, 1, 2'd1, 0, 3'd0);
    alloc_seq(0, 0, 2'd0, 0, 3'd1);
    alloc_seq(0, 0, 2'd1, 0, 3'd2);
    alloc_seq(0, 0, 2'd2, 0, 3'd3);
    alloc_seq(0, 0, 2'd3, 0, 3'd4);
    chk("full_flag", reqs_full, 1);
    cpu_valid = 1;
    settle();
    chk("full_no_grant", cpu_ready, 0);
    chk("full_op_idle", reqs_op_code, 0);
    tick();
    free_valid = 1;
    settle();
    chk("full_no_grant2", cpu_ready, 0);
    tick();
    free_valid = 0;
    settle();
    chk("free_cnt", reqs_cnt, 3);
    chk("free_not_full", reqs_full, 0);
    chk("free_then_grant", cpu_ready, 1);
    chk("free_grant_op", reqs_op_code, 2);
    tick();
    cpu_valid = 0;
    tick();
    settle();
    chk("refill_strobe", fill_reqs, 1);
    tick();
    settle();
    chk("refill_cnt", reqs_cnt, 4);
    free_valid = 1;
    tick();
    tick();
    free_valid = 0;
    settle();
    chk("free2_cnt", reqs_cnt, 2);
    // fill and free in the same cycle at count 2
    alloc_seq(0, 0, 2'd0, 1, 3'd2);

    // cpu and flush both held: strict alternation
    do_reset();
    cpu_valid = 1; flush_valid = 1;
    for (int g = 0; g < 4; g++) begin
      bit fl;
      fl = g[0];
      settle();
      chk("alt_cpu_ready", cpu_ready, !fl);
      chk("alt_flush_ready", flush_ready, fl);
      chk("alt_op", reqs_op_code, fl ? 32'd3 : 32'd2);
      tick();
      settle();
      tick();
      settle();
      chk("alt_fill", fill_reqs, !fl);
      chk("alt_fill_flush", fill_reqs_flush, fl);
      chk("alt_done_src", done_src, fl ? 32'd3 : 32'd2);
      tick();
    end
    cpu_valid = 0; flush_valid = 0;
    settle();
    chk("alt_cnt", reqs_cnt, 4);
    chk("alt_full", reqs_full, 1);

    // starvation: fwd wins 8 times, cpu forced on the 9th IDLE
    do_reset();
    fwd_valid = 1; cpu_valid = 1; reqs_hit = 0; reqs_i = 1;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("starve_fwd_win", fwd_ready, 1);
      chk("starve_cpu_lose", cpu_ready, 0);
      chk("starve_fwd_op", reqs_op_code, 4);
      tick();
      tick();
      settle();
      if (k == 0) begin
        chk("fwd_done_src", done_src, 1);
        chk("fwd_done_hit", done_hit, 0);
        chk("fwd_done_idx", done_idx, 1);
      end
      tick();
    end
    settle();
    chk("starve_cpu_forced", cpu_ready, 1);
    chk("starve_fwd_blocked", fwd_ready, 0);
    chk("starve_cpu_op", reqs_op_code, 2);
    tick();
    tick();
    settle();
    chk("starve_cpu_fill", fill_reqs, 1);
    tick();
    settle();
    chk("starve_cleared_fwd", fwd_ready, 1);
    chk("starve_cleared_cpu", cpu_ready, 0);
    tick();
    fwd_valid = 0; cpu_valid = 0;
    tick();
    tick();
    settle();

    // free at zero sets sticky error
    do_reset();
    free_valid = 1;
    tick();
    free_valid = 0;
    settle();
    chk("underflow_ovf", ovf_err, 1);
    chk("underflow_cnt", reqs_cnt, 0);
    tick();
    tick();
    settle();
    chk("ovf_sticky", ovf_err, 1);

    // reset during the peek of a cpu grant
    cpu_valid = 1;
    settle();
    chk("midrst_grant", cpu_ready, 1);
    tick();
    cpu_valid = 0;
    settle();
    chk("midrst_peek_op", reqs_op_code, 2);
    rst = 0;
    #1;
    chk("midrst_op", reqs_op_code, 0);
    chk("midrst_ovf", ovf_err, 0);
    chk("midrst_cnt", reqs_cnt, 0);
    chk("midrst_done", done_valid, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      settle();
      chk("midrst_fill_in_rst", fill_reqs, 0);
    end
    rst = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      settle();
      chk("midrst_fill_after", fill_reqs, 0);
      chk("midrst_done_after", done_valid, 0);
    end
    chk("midrst_cnt_after", reqs_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/l2_reqs_sched.md
Name: l2_reqs_sched

Overview:
- Scheduler in front of the L2 request buffer.
- Serialises four requesters onto the single 3-bit request-buffer opcode port:
  - rsp lookup
  - fwd peek
  - cpu-req peek+fill
  - flush peek+fill
- Tracks buffer occupancy, latches peek results, and issues the fill strobe only when a free entry exists and no set conflict was reported.
- Sits between the L2 input-channel decode and the request buffer.

Parameters:
- N_REQS, 4: request-buffer entries.
- REQS_BITS, 2: entry index width, clog2(N_REQS).
- STARVE_LIMIT, 8: consecutive lost arbitrations before a cpu-req/flush requester is forced.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- rsp_valid  in  1  lookup request; rsp_ready  out  1  grant pulse
- fwd_valid  in  1  fwd peek request; fwd_ready  out  1  grant pulse
- cpu_valid  in  1  cpu-req allocation request; cpu_ready  out  1  grant pulse
- flush_valid  in  1  flush allocation request; flush_ready  out  1  grant pulse
- free_valid  in  1  one entry returned to INVALID this cycle
- set_set_conflict_reqs  in  1  peek-req conflict (combinational, peek cycle)
- reqs_hit  in  1  registered hit from buffer
- reqs_i  in  REQS_BITS  registered index from buffer
- reqs_op_code  out  3  L2_REQS_IDLE/LOOKUP/PEEK_REQ/PEEK_FLUSH/PEEK_FWD
- fill_reqs  out  1  fill strobe, cpu path
- fill_reqs_flush  out  1  fill strobe, flush path
- done_valid  out  1  result pulse
- done_src  out  2  0=rsp, 1=fwd, 2=cpu, 3=flush
- done_hit  out  1  hit (rsp/fwd) or allocated (cpu/flush)
- done_conflict  out  1  cpu peek aborted on set conflict
- done_idx  out  REQS_BITS  entry index
- reqs_cnt  out  REQS_BITS+1  occupancy
- reqs_full  out  1  reqs_cnt==N_REQS
- ovf_err  out  1  sticky: free at count 0, or count overflow

Behaviour:
- Reset values:
  - state=IDLE, reqs_op_code=L2_REQS_IDLE.
  - All ready/done/fill outputs 0, reqs_cnt=0, reqs_full=0, ovf_err=0.
  - Starvation counter=0, rr pointer=cpu.
- FSM states: IDLE, PEEK, RESULT.
- IDLE: pick a winner, assert its *_ready for one cycle, drive its opcode the same cycle, then go to PEEK. No requester valid means stay in IDLE with opcode IDLE.
- Priority:
  - rsp > fwd > {cpu, flush} round-robin.
  - cpu/flush are eligible only when !reqs_full.
  - rr pointer toggles after every cpu/flush grant.
- Starvation:
  - Counter increments each IDLE cycle in which an eligible cpu/flush loses to rsp/fwd. Reset to 0 on a cpu/flush grant.
  - Counter == STARVE_LIMIT: the eligible cpu/flush requester beats rsp and fwd.
  - Counter saturates at STARVE_LIMIT.
- PEEK:
  - Opcode held one cycle. The buffer registers reqs_i/reqs_hit at the end of this cycle.
  - For cpu, latch set_set_conflict_reqs. Go to RESULT.
- RESULT:
  - Opcode IDLE. done_valid=1, done_src=winner, done_idx=reqs_i.
  - rsp/fwd: done_hit=reqs_hit.
  - cpu with latched conflict: done_conflict=1, done_hit=0, no fill.
  - cpu without conflict: fill_reqs=1 this cycle, done_hit=1.
  - flush: fill_reqs_flush=1 this cycle, done_hit=1.
  - Return to IDLE.
- Latency: grant to done is 2 cycles. Back-to-back grants occur every 3 cycles.
- Occupancy:
  - +1 on fill_reqs or fill_reqs_flush; −1 on free_valid; unchanged when both occur together.
  - free_valid at count 0: count stays 0 and ovf_err is set.
  - Fill at N_REQS is impossible by eligibility. If it occurs anyway: ovf_err is set and count saturates.
  - reqs_full is combinational from reqs_cnt.
- Fullness re-check: reqs_full is evaluated only in IDLE. An entry freed during PEEK/RESULT does not cancel the outstanding sequence.
- Valid signals are level; a requester holds valid until its ready pulse. Deasserting valid without a grant is legal.
- Reset mid-sequence: the FSM aborts to IDLE immediately and no fill strobe is issued.

Decomposition:
- cache_consts.svh:
  - L2_REQS_* opcodes.
  - N_REQS, REQS_BITS.
  - New L2_SCHED_SRC_RSP/FWD/CPU/FLUSH (2-bit) source encodings.
- cache_types.svh: l2_sched_state_t enum (IDLE, PEEK, RESULT).
- One sub-module, l2_reqs_sched_arb: the combinational priority, rr and starvation select.
- The FSM and occupancy counter stay in the top module.

Test Plan:
- rsp_valid=1 alone, reqs_hit=1, reqs_i=2 at RESULT:
  - Cycle 0: rsp_ready=1, opcode LOOKUP.
  - Cycle 1: opcode LOOKUP.
  - Cycle 2: done_valid=1, done_src=0, done_hit=1, done_idx=2.
- cpu_valid with conflict:
  - set_set_conflict_reqs=1 during PEEK gives done_conflict=1 and fill_reqs=0; reqs_cnt stays 0.
  - Repeat without conflict: fill_reqs=1 and reqs_cnt becomes 1.
- Fill to full:
  - 4 cpu allocations give reqs_cnt=4 and reqs_full=1; cpu_valid is then not granted.
  - free_valid pulse gives reqs_cnt=3 and a cpu grant in the next IDLE.
- cpu_valid and flush_valid both held: grants alternate cpu, flush, cpu, flush. opcodes are PEEK_REQ/PEEK_FLUSH and strobes are fill_reqs/fill_reqs_flush.
- fwd_valid held continuously with cpu_valid held:
  - cpu loses 8 times, then is granted on the 9th IDLE.
  - Starvation counter returns to 0.
- Counter edges:
  - free_valid at reqs_cnt=0 gives ovf_err=1 (sticky), reqs_cnt=0.
  - Fill and free in the same cycle at reqs_cnt=2 leave reqs_cnt=2.
  - rst low during PEEK of a cpu grant: all outputs reset, and no fill_reqs ever pulses.
